ext_mem_read_arbiter: RTL and testbench

//  Shares the single external-memory read port (72b cmd / 64b data) between the display reader
//  (real-time, priority) and the MC reference fetcher (decoder). Arbitrates commands, tracks

---
 rtl/ext_mem_read_arbiter_if.sv | 54 +++++
 rtl/ext_mem_read_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_ext_mem_read_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_read_arbiter_if.sv
// ext_mem_read_arbiter_if
//   Bundles the requester, memory-controller and data-return handshakes
//   around ext_mem_read_arbiter.
//   slave  : arbiter side (consumes commands, drives grants and return data)
//   master : environment side (display reader, MC fetcher, memory controller)
//   Commands are 72 bits {SADDR[31:0], 8'b0, Type[8:0], BTT[22:0]}.
//   Data beats are 64 bits.
interface ext_mem_read_arbiter_if;
    logic        disp_cmd_valid;
    logic        disp_cmd_ready;
    logic [71:0] disp_cmd_data;
    logic        mc_cmd_valid;
    logic        mc_cmd_ready;
    logic [71:0] mc_cmd_data;
    logic        ext_mem_reader_cmd_valid;
    logic        ext_mem_reader_cmd_ready;
    logic [71:0] ext_mem_reader_cmd_data;
    logic        ext_mem_reader_data_valid;
    logic        ext_mem_reader_data_ready;
    logic [63:0] ext_mem_reader_data;
    logic        disp_data_valid;
    logic [63:0] disp_data;
    logic        mc_data_valid;
    logic        mc_data_ready;
    logic [63:0] mc_data;

    modport slave (
        input  disp_cmd_valid, disp_cmd_data,
        output disp_cmd_ready,
        input  mc_cmd_valid, mc_cmd_data,
        output mc_cmd_ready,
        output ext_mem_reader_cmd_valid, ext_mem_reader_cmd_data,
        input  ext_mem_reader_cmd_ready,
        input  ext_mem_reader_data_valid, ext_mem_reader_data,
        output ext_mem_reader_data_ready,
        output disp_data_valid, disp_data,
        output mc_data_valid, mc_data,
        input  mc_data_ready
    );

    modport master (
        output disp_cmd_valid, disp_cmd_data,
        input  disp_cmd_ready,
        output mc_cmd_valid, mc_cmd_data,
        input  mc_cmd_ready,
        input  ext_mem_reader_cmd_valid, ext_mem_reader_cmd_data,
        output ext_mem_reader_cmd_ready,
        output ext_mem_reader_data_valid, ext_mem_reader_data,
        input  ext_mem_reader_data_ready,
        input  disp_data_valid, disp_data,
        input  mc_data_valid, mc_data,
        output mc_data_ready
    );
endinterface

// File: rtl/ext_mem_read_arbiter.sv
// ext_mem_read_arbiter
//   Shares the external-memory read port between the display reader
//   (real-time, normally wins) and the MC reference fetcher. Granted commands
//   are registered towards the memory controller, a tag {src, beats} per
//   burst is kept in issue order, and returned beats are steered to the
//   issuer named by the oldest tag.
// Ports
//   mem_reader_clk      : single clock
//   rst_n               : asynchronous active-low reset
//   bus (slave)         : command, memory and return handshakes
//   busy                : command register valid or bursts outstanding
//   err_unexpected_data : sticky, a beat arrived with no burst outstanding
// Optional build macro
//   MEM_ARB_STATS_EN    : adds disp_burst_count, mc_burst_count and
//                         mc_stall_cycles (32-bit, wrapping) output ports
module ext_mem_read_arbiter #(
    parameter int MaxOutstanding     = 4,
    parameter int Log2MaxOutstanding = 2,
    parameter int StarveLimit        = 8
) (
    input  logic                         mem_reader_clk,
    input  logic                         rst_n,
    ext_mem_read_arbiter_if.slave        bus,
    output logic                         busy,
    output logic                         err_unexpected_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]                  disp_burst_count,
    output logic [31:0]                  mc_burst_count,
    output logic [31:0]                  mc_stall_cycles
`endif
);

    // One bit more than 20 so that the largest BTT (ceil((2^23-1)/8) = 2^20)
    // still fits.
    localparam int BeatsW  = 21;
    localparam int StarveW = $clog2(StarveLimit + 1);
    localparam int CountW  = Log2MaxOutstanding + 1;

    localparam logic SrcDisp = 1'b0;
    localparam logic SrcMc   = 1'b1;

    logic                          cmd_valid_q;
    logic [71:0]                   cmd_data_q;
    logic                          tag_src_q   [MaxOutstanding];
    logic [BeatsW-1:0]             tag_beats_q [MaxOutstanding];
    logic [Log2MaxOutstanding-1:0] wr_ptr_q;
    logic [Log2MaxOutstanding-1:0] rd_ptr_q;
    logic [CountW-1:0]             count_q;
    logic [BeatsW-1:0]             beat_cnt_q;
    logic                          beat_cnt_loaded_q;
    logic [StarveW-1:0]            starve_cnt_q;
    logic                          err_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              slot_open;
    logic              mc_wins;
    logic              grant_disp;
    logic              grant_mc;
    logic              grant;
    logic [71:0]       grant_data;
    logic [BeatsW-1:0] grant_beats;
    logic              push;
    logic              head_src;
    logic [BeatsW-1:0] cur_beats;
    logic              data_ready;
    logic              beat_acc;
    logic              pop;

    // Arbitration. A full tag FIFO blocks the grant even when the head tag
    // retires in the same cycle, which keeps the full check off the data path.
    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CountW'(MaxOutstanding));
        slot_open   = (!cmd_valid_q || bus.ext_mem_reader_cmd_ready) && !fifo_full;
        mc_wins     = bus.mc_cmd_valid &&
                      ((starve_cnt_q >= StarveW'(StarveLimit)) || !bus.disp_cmd_valid);
        grant_mc    = slot_open && mc_wins;
        grant_disp  = slot_open && bus.disp_cmd_valid && !mc_wins;
        grant       = grant_mc || grant_disp;
        grant_data  = grant_mc ? bus.mc_cmd_data : bus.disp_cmd_data;
        // ceil(BTT/8) on the BTT field in bits [22:0]
        grant_beats = BeatsW'(grant_data[22:3]) + BeatsW'(|grant_data[2:0]);
        push        = grant && (grant_data[22:0] != '0);
    end

    // Return steering. Until the head burst has taken its first beat the
    // count comes straight from the tag, so back-to-back bursts need no bubble.
    // With nothing outstanding any beat is accepted and dropped.
    always_comb begin
        head_src   = tag_src_q[rd_ptr_q];
        cur_beats  = beat_cnt_loaded_q ? beat_cnt_q : tag_beats_q[rd_ptr_q];
        if (fifo_empty) begin
            data_ready = bus.ext_mem_reader_data_valid;
        end else if (head_src == SrcMc) begin
            data_ready = bus.mc_data_ready;
        end else begin
            data_ready = 1'b1;
        end
        beat_acc = bus.ext_mem_reader_data_valid && data_ready;
        pop      = beat_acc && !fifo_empty && (cur_beats == BeatsW'(1));
    end

    assign bus.mc_cmd_ready              = grant_mc;
    assign bus.disp_cmd_ready            = grant_disp;
    assign bus.ext_mem_reader_cmd_valid  = cmd_valid_q;
    assign bus.ext_mem_reader_cmd_data   = cmd_data_q;
    assign bus.ext_mem_reader_data_ready = data_ready;
    assign bus.disp_data_valid = bus.ext_mem_reader_data_valid && !fifo_empty && (head_src == SrcDisp);
    assign bus.mc_data_valid   = bus.ext_mem_reader_data_valid && !fifo_empty && (head_src == SrcMc);
    assign bus.disp_data       = bus.ext_mem_reader_data;
    assign bus.mc_data         = bus.ext_mem_reader_data;
    assign busy                = cmd_valid_q || !fifo_empty;
    assign err_unexpected_data = err_q;

    // Command register: holds while the memory controller stalls.
    always_ff @(posedge mem_reader_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
        end else if (!cmd_valid_q || bus.ext_mem_reader_cmd_ready) begin
            cmd_valid_q <= grant;
            if (grant) begin
                cmd_data_q <= grant_data;
            end
        end
    end

    // Tag FIFO in issue order; zero-length bursts leave no tag.
    always_ff @(posedge mem_reader_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                tag_src_q[i]   <= SrcDisp;
                tag_beats_q[i] <= '0;
            end
        end else begin
            if (push) begin
                tag_src_q[wr_ptr_q]   <= grant_mc;
                tag_beats_q[wr_ptr_q] <= grant_beats;
                wr_ptr_q              <= wr_ptr_q + Log2MaxOutstanding'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + Log2MaxOutstanding'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CountW'(1);
                2'b01:   count_q <= count_q - CountW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Remaining beats of the head burst.
    always_ff @(posedge mem_reader_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q        <= '0;
            beat_cnt_loaded_q <= 1'b0;
        end else if (beat_acc && !fifo_empty) begin
            if (pop) begin
                beat_cnt_loaded_q <= 1'b0;
            end else begin
                beat_cnt_q        <= cur_beats - BeatsW'(1);
                beat_cnt_loaded_q <= 1'b1;
            end
        end
    end

    // Consecutive display wins while MC is waiting; saturates at the limit.
    always_ff @(posedge mem_reader_clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else if (!bus.mc_cmd_valid || grant_mc) begin
            starve_cnt_q <= '0;
        end else if (grant_disp && (starve_cnt_q < StarveW'(StarveLimit))) begin
            starve_cnt_q <= starve_cnt_q + StarveW'(1);
        end
    end

    always_ff @(posedge mem_reader_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (beat_acc && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge mem_reader_clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_burst_count <= '0;
            mc_burst_count   <= '0;
            mc_stall_cycles  <= '0;
        end else begin
            if (grant_disp) begin
                disp_burst_count <= disp_burst_count + 32'd1;
            end
            if (grant_mc) begin
                mc_burst_count <= mc_burst_count + 32'd1;
            end
            if (bus.mc_cmd_valid && !grant_mc) begin
                mc_stall_cycles <= mc_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ext_mem_read_arbiter.sv
// tb_ext_mem_read_arbiter
//   Randomised traffic from two requesters and a memory-controller model,
//   compared every cycle against a queue-based reference of the arbiter.
`timescale 1ns/1ps
module tb_ext_mem_read_arbiter;

    localparam int MaxOut    = 4;
    localparam int StarveLim = 8;

    logic mem_reader_clk = 1'b0;
    logic rst_n;
    logic busy;
    logic err_unexpected_data;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] disp_burst_count;
    logic [31:0] mc_burst_count;
    logic [31:0] mc_stall_cycles;
`endif

    always #5 mem_reader_clk = ~mem_reader_clk;

    ext_mem_read_arbiter_if bus ();

    ext_mem_read_arbiter #(
        .MaxOutstanding     (MaxOut),
        .Log2MaxOutstanding (2),
        .StarveLimit        (StarveLim)
    ) dut (
        .mem_reader_clk      (mem_reader_clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .busy                (busy),
        .err_unexpected_data (err_unexpected_data)
`ifdef MEM_ARB_STATS_EN
        ,
        .disp_burst_count    (disp_burst_count),
        .mc_burst_count      (mc_burst_count),
        .mc_stall_cycles     (mc_stall_cycles)
`endif
    );

    typedef struct {
        bit is_mc;
        int beats_left;
    } burst_t;

    // Reference state
    burst_t      tag_q[$];
    int          mem_pending[$];
    bit          m_cmd_valid;
    logic [71:0] m_cmd_data;
    int          m_starve;
    bit          m_err;
    int          s_disp, s_mc, s_stall;

    // Traffic knobs (percent chances)
    int p_disp, p_mc, p_cmd_ready, p_data, p_mc_ready;
    bit force_stray;
    bit disp_taken, mc_taken, beat_taken;

    int num_checks = 0;
    int num_errors = 0;

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    function automatic int beatsOf(input logic [71:0] cmd);
        int btt;
        btt = int'(cmd[22:0]);
        return (btt + 7) / 8;
    endfunction

    function automatic logic [71:0] randCmd();
        int   sel;
        logic [22:0] btt;
        logic [8:0]  typ;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      btt = 23'd0;
        else if (sel == 1) btt = 23'd128;
        else               btt = 23'($urandom_range(1, 64));
        typ = 9'($urandom_range(0, 511));
        return {32'($urandom), 8'h00, typ, btt};
    endfunction

    // Compare all outputs for the current inputs, then advance the reference
    // to the state after the coming clock edge.
    task automatic evaluateCycle();
        bit slot, mc_win, e_disp_rdy, e_mc_rdy, e_data_rdy, e_dv, e_mv;
        bit g_disp, g_mc, acc_beat;
        int b;
        burst_t h;
        slot       = (!m_cmd_valid || bus.ext_mem_reader_cmd_ready) && (tag_q.size() < MaxOut);
        mc_win     = bus.mc_cmd_valid && ((m_starve >= StarveLim) || !bus.disp_cmd_valid);
        e_disp_rdy = slot && bus.disp_cmd_valid && !mc_win;
        e_mc_rdy   = slot && mc_win;
        if (tag_q.size() == 0) begin
            e_data_rdy = bus.ext_mem_reader_data_valid;
            e_dv = 1'b0;
            e_mv = 1'b0;
        end else begin
            e_data_rdy = tag_q[0].is_mc ? bus.mc_data_ready : 1'b1;
            e_dv = bus.ext_mem_reader_data_valid && !tag_q[0].is_mc;
            e_mv = bus.ext_mem_reader_data_valid && tag_q[0].is_mc;
        end

        checkOutput("disp_cmd_ready", 72'(bus.disp_cmd_ready), 72'(e_disp_rdy));
        checkOutput("mc_cmd_ready", 72'(bus.mc_cmd_ready), 72'(e_mc_rdy));
        checkOutput("cmd_valid", 72'(bus.ext_mem_reader_cmd_valid), 72'(m_cmd_valid));
        if (m_cmd_valid) checkOutput("cmd_data", bus.ext_mem_reader_cmd_data, m_cmd_data);
        checkOutput("data_ready", 72'(bus.ext_mem_reader_data_ready), 72'(e_data_rdy));
        checkOutput("disp_data_valid", 72'(bus.disp_data_valid), 72'(e_dv));
        checkOutput("mc_data_valid", 72'(bus.mc_data_valid), 72'(e_mv));
        if (e_dv) checkOutput("disp_data", 72'(bus.disp_data), 72'(bus.ext_mem_reader_data));
        if (e_mv) checkOutput("mc_data", 72'(bus.mc_data), 72'(bus.ext_mem_reader_data));
        checkOutput("busy", 72'(busy), 72'(m_cmd_valid || (tag_q.size() > 0)));
        checkOutput("err", 72'(err_unexpected_data), 72'(m_err));
`ifdef MEM_ARB_STATS_EN
        checkOutput("disp_burst_count", 72'(disp_burst_count), 72'(32'(s_disp)));
        checkOutput("mc_burst_count", 72'(mc_burst_count), 72'(32'(s_mc)));
        checkOutput("mc_stall_cycles", 72'(mc_stall_cycles), 72'(32'(s_stall)));
`endif

        g_disp   = bus.disp_cmd_valid && e_disp_rdy;
        g_mc     = bus.mc_cmd_valid && e_mc_rdy;
        acc_beat = bus.ext_mem_reader_data_valid && e_data_rdy;

        if (m_cmd_valid && bus.ext_mem_reader_cmd_ready) begin
            b = beatsOf(m_cmd_data);
            if (b > 0) mem_pending.push_back(b);
        end
        if (!m_cmd_valid || bus.ext_mem_reader_cmd_ready) begin
            m_cmd_valid = g_disp || g_mc;
            if (g_mc)        m_cmd_data = bus.mc_cmd_data;
            else if (g_disp) m_cmd_data = bus.disp_cmd_data;
        end
        if (acc_beat) begin
            if (tag_q.size() == 0) begin
                m_err = 1'b1;
            end else begin
                h = tag_q[0];
                h.beats_left--;
                if (h.beats_left == 0) void'(tag_q.pop_front());
                else tag_q[0] = h;
            end
            if (mem_pending.size() > 0) begin
                mem_pending[0]--;
                if (mem_pending[0] == 0) void'(mem_pending.pop_front());
            end
        end
        if (g_disp || g_mc) begin
            b = beatsOf(g_mc ? bus.mc_cmd_data : bus.disp_cmd_data);
            if (b > 0) tag_q.push_back('{is_mc: g_mc, beats_left: b});
        end
        if (!bus.mc_cmd_valid || g_mc) m_starve = 0;
        else if (g_disp && (m_starve < StarveLim)) m_starve++;
        if (g_disp) s_disp++;
        if (g_mc) s_mc++;
        if (bus.mc_cmd_valid && !g_mc) s_stall++;

        disp_taken = g_disp;
        mc_taken   = g_mc;
        beat_taken = acc_beat;
    endtask

    // One clock of traffic: requesters hold a command until it is taken,
    // memory holds a beat until it is taken.
    task automatic applyStimulus();
        @(negedge mem_reader_clk);
        if (disp_taken) bus.disp_cmd_valid = 1'b0;
        if (mc_taken)   bus.mc_cmd_valid   = 1'b0;
        if (beat_taken) bus.ext_mem_reader_data_valid = 1'b0;
        if (!bus.disp_cmd_valid && chance(p_disp)) begin
            bus.disp_cmd_valid = 1'b1;
            bus.disp_cmd_data  = randCmd();
        end
        if (!bus.mc_cmd_valid && chance(p_mc)) begin
            bus.mc_cmd_valid = 1'b1;
            bus.mc_cmd_data  = randCmd();
        end
        bus.ext_mem_reader_cmd_ready = chance(p_cmd_ready);
        bus.mc_data_ready            = chance(p_mc_ready);
        if (!bus.ext_mem_reader_data_valid &&
            (force_stray || ((mem_pending.size() > 0) && chance(p_data)))) begin
            bus.ext_mem_reader_data_valid = 1'b1;
            bus.ext_mem_reader_data       = {32'($urandom), 32'($urandom)};
        end
        #1;
        evaluateCycle();
    endtask

    task automatic setKnobs(input int pd, input int pm, input int pcr, input int pdat, input int pmr);
        p_disp = pd; p_mc = pm; p_cmd_ready = pcr; p_data = pdat; p_mc_ready = pmr;
    endtask

    // Reset asserted at a falling edge, so it lands mid-cycle and mid-burst.
    task automatic doReset();
        @(negedge mem_reader_clk);
        bus.disp_cmd_valid = 1'b0;
        bus.disp_cmd_data  = '0;
        bus.mc_cmd_valid   = 1'b0;
        bus.mc_cmd_data    = '0;
        bus.ext_mem_reader_cmd_ready  = 1'b0;
        bus.ext_mem_reader_data_valid = 1'b0;
        bus.ext_mem_reader_data       = '0;
        bus.mc_data_ready  = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_cmd_valid", 72'(bus.ext_mem_reader_cmd_valid), 72'd0);
        checkOutput("rst_cmd_data", bus.ext_mem_reader_cmd_data, 72'd0);
        checkOutput("rst_disp_cmd_ready", 72'(bus.disp_cmd_ready), 72'd0);
        checkOutput("rst_mc_cmd_ready", 72'(bus.mc_cmd_ready), 72'd0);
        checkOutput("rst_data_ready", 72'(bus.ext_mem_reader_data_ready), 72'd0);
        checkOutput("rst_disp_data_valid", 72'(bus.disp_data_valid), 72'd0);
        checkOutput("rst_mc_data_valid", 72'(bus.mc_data_valid), 72'd0);
        checkOutput("rst_busy", 72'(busy), 72'd0);
        checkOutput("rst_err", 72'(err_unexpected_data), 72'd0);
`ifdef MEM_ARB_STATS_EN
        checkOutput("rst_disp_burst_count", 72'(disp_burst_count), 72'd0);
        checkOutput("rst_mc_burst_count", 72'(mc_burst_count), 72'd0);
        checkOutput("rst_mc_stall_cycles", 72'(mc_stall_cycles), 72'd0);
`endif
        tag_q.delete();
        mem_pending.delete();
        m_cmd_valid = 1'b0;
        m_cmd_data  = '0;
        m_starve    = 0;
        m_err       = 1'b0;
        s_disp = 0; s_mc = 0; s_stall = 0;
        disp_taken = 1'b0; mc_taken = 1'b0; beat_taken = 1'b0;
        repeat (2) @(posedge mem_reader_clk);
        @(negedge mem_reader_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        force_stray = 1'b0;
        setKnobs(0, 0, 0, 0, 0);
        $display("[TB] start");
        doReset();

        // Mixed traffic
        setKnobs(50, 50, 70, 70, 60);
        repeat (300) applyStimulus();

        // Both requesters always asking: display wins until MC starves
        setKnobs(100, 100, 100, 100, 100);
        repeat (300) applyStimulus();

        // No data returns: tag FIFO fills and blocks grants, then drains
        setKnobs(80, 80, 90, 0, 100);
        repeat (40) applyStimulus();
        setKnobs(30, 30, 90, 90, 100);
        repeat (60) applyStimulus();

        // MC sink mostly stalled
        setKnobs(40, 70, 80, 90, 10);
        repeat (200) applyStimulus();

        // Reset in the middle of traffic
        setKnobs(60, 60, 80, 80, 50);
        repeat (25) applyStimulus();
        doReset();

        // Stray beat with nothing outstanding sets the sticky error
        setKnobs(0, 0, 100, 0, 100);
        repeat (3) applyStimulus();
        force_stray = 1'b1;
        applyStimulus();
        force_stray = 1'b0;
        repeat (5) applyStimulus();

        // Traffic after the error; the flag must stay set
        setKnobs(50, 50, 70, 70, 60);
        repeat (200) applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
